// File: rtl/hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : hex_keypad_entry
// Brief    : 4x4 matrix keypad scanner/debouncer feeding a 4-hex-digit entry
//            register. Define KEYPAD_CLEAR_EN to make key F clear the entry.
// Revision : 1.0 - initial release
// ============================================================================
module hex_keypad_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        G_CLOCK_50,
  input  logic        G_RESET_N,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        digit_valid,
  output logic        key_pressed
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_db_ticks = CNT_W'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_col_meta, r_col_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row, w_row_nxt;
  logic [3:0]       r_code, w_code_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]      r_value, w_value_nxt;
  logic [3:0]       r_key_code, w_key_code_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_pressed, w_pressed_nxt;
  logic             w_tick;
  logic             w_any_low;
  logic [1:0]       w_col;
  logic             w_accept;

  assign w_tick    = (r_div == c_div_last);
  assign w_any_low = (r_col_sync != 4'hF);

  // Lowest-numbered closed column wins when several are low.
  always_comb begin
    w_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_col_sync[i]) w_col = 2'(i);
    end
  end

  always_ff @(posedge G_CLOCK_50 or negedge G_RESET_N) begin
    if (!G_RESET_N) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_div      <= '0;
      r_state    <= SCAN;
      r_row      <= 2'd0;
      r_code     <= 4'h0;
      r_cnt      <= '0;
      r_value    <= 16'h0000;
      r_key_code <= 4'h0;
      r_valid    <= 1'b0;
      r_pressed  <= 1'b0;
    end else begin
      r_col_meta <= col_n;
      r_col_sync <= r_col_meta;
      r_div      <= w_tick ? '0 : r_div + 1'b1;
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_code     <= w_code_nxt;
      r_cnt      <= w_cnt_nxt;
      r_value    <= w_value_nxt;
      r_key_code <= w_key_code_nxt;
      r_valid    <= w_valid_nxt;
      r_pressed  <= w_pressed_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_code_nxt     = r_code;
    w_cnt_nxt      = r_cnt;
    w_value_nxt    = r_value;
    w_key_code_nxt = r_key_code;
    w_valid_nxt    = 1'b0;
    w_pressed_nxt  = r_pressed;
    w_accept       = 1'b0;

    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_any_low) begin
            w_code_nxt = {r_row, w_col};
            w_cnt_nxt  = CNT_W'(1);
            if (w_cnt_nxt == c_db_ticks) w_accept = 1'b1;
            else                         w_state_nxt = DEBOUNCE;
          end else begin
            w_row_nxt = r_row + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (w_any_low && (w_col == r_code[1:0])) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_nxt == c_db_ticks) w_accept = 1'b1;
          end else begin
            w_state_nxt = SCAN;
            w_row_nxt   = r_row + 2'd1;
            w_cnt_nxt   = '0;
          end
        end
        HELD: begin
          // Counter now tracks consecutive released samples of the held column.
          if (r_col_sync[r_code[1:0]]) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_nxt == c_db_ticks) begin
              w_pressed_nxt = 1'b0;
              w_state_nxt   = SCAN;
              w_row_nxt     = r_row + 2'd1;
              w_cnt_nxt     = '0;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    if (w_accept) begin
      w_state_nxt    = HELD;
      w_cnt_nxt      = '0;
      w_key_code_nxt = w_code_nxt;
      w_pressed_nxt  = 1'b1;
`ifdef KEYPAD_CLEAR_EN
      if (w_code_nxt == 4'hF) begin
        w_value_nxt = 16'h0000;
      end else begin
        w_value_nxt = {r_value[11:0], w_code_nxt};
        w_valid_nxt = 1'b1;
      end
`else
      w_value_nxt = {r_value[11:0], w_code_nxt};
      w_valid_nxt = 1'b1;
`endif
    end
  end

  assign row_n       = ~(4'b0001 << r_row);
  assign value       = r_value;
  assign key_code    = r_key_code;
  assign digit_valid = r_valid;
  assign key_pressed = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_keypad_entry
// Brief    : Keypad matrix model plus tick-level reference for hex_keypad_entry;
//            honours KEYPAD_CLEAR_EN for the clear-key expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_entry;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        digit_valid;
  logic        key_pressed;

  int n_vec = 0;
  int n_err = 0;
  int n_pulses = 0;

  hex_keypad_entry #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) dut (
    .G_CLOCK_50  (clk),
    .G_RESET_N   (rst_n),
    .col_n       (col_n),
    .row_n       (row_n),
    .value       (value),
    .key_code    (key_code),
    .digit_valid (digit_valid),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key shorts its row line to its column line.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model, advanced once per clock edge ----------------
  int          m_div = 0, m_row = 0, m_phase = 0, m_code = 0, m_cnt = 0;
  logic [15:0] m_value = '0;
  logic [3:0]  m_key = '0;
  bit          m_valid = 0, m_pressed = 0;
  logic [3:0]  m_hist0 = 4'hF, m_hist1 = 4'hF;

  function automatic logic [3:0] pad_cols(input int row, input logic [15:0] k);
    logic [3:0] cols = 4'hF;
    for (int c = 0; c < 4; c++) if (k[4*row+c]) cols[c] = 1'b0;
    return cols;
  endfunction

  task automatic model_reset();
    m_div = 0; m_row = 0; m_phase = 0; m_code = 0; m_cnt = 0;
    m_value = '0; m_key = '0; m_valid = 0; m_pressed = 0;
    m_hist0 = 4'hF; m_hist1 = 4'hF;
  endtask

  task automatic model_accept();
    m_phase = 2; m_cnt = 0; m_key = 4'(m_code); m_pressed = 1;
`ifdef KEYPAD_CLEAR_EN
    if (m_code == 15) m_value = 16'h0000;
    else begin m_value = (m_value << 4) | 16'(m_code); m_valid = 1; end
`else
    m_value = (m_value << 4) | 16'(m_code); m_valid = 1;
`endif
  endtask

  task automatic model_step();
    logic [3:0] seen;
    bit tick, low;
    int win;
    seen    = m_hist1;                       // columns as seen two edges late
    m_hist1 = m_hist0;
    m_hist0 = pad_cols(m_row, keys);
    m_valid = 0;
    tick    = (m_div == SCAN_DIV - 1);
    m_div   = (m_div + 1) % SCAN_DIV;
    if (!tick) return;
    low = (seen != 4'hF);
    win = 0;
    for (int c = 3; c >= 0; c--) if (!seen[c]) win = c;
    if (m_phase == 0) begin
      if (low) begin
        m_code = 4 * m_row + win; m_cnt = 1;
        if (m_cnt == DEBOUNCE_TICKS) model_accept(); else m_phase = 1;
      end else m_row = (m_row + 1) % 4;
    end else if (m_phase == 1) begin
      if (low && win == m_code % 4) begin
        m_cnt++;
        if (m_cnt == DEBOUNCE_TICKS) model_accept();
      end else begin
        m_phase = 0; m_cnt = 0; m_row = (m_row + 1) % 4;
      end
    end else begin
      if (seen[m_code % 4]) begin
        m_cnt++;
        if (m_cnt == DEBOUNCE_TICKS) begin
          m_pressed = 0; m_phase = 0; m_cnt = 0; m_row = (m_row + 1) % 4;
        end
      end else m_cnt = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Mid-cycle comparison of every output against the model.
  bit prev_valid = 0;
  always @(negedge clk) begin
    logic [3:0] exp_row;
    exp_row = 4'hF ^ (4'h1 << m_row);
    chk("row_n", 32'(row_n), 32'(exp_row));
    chk("value", 32'(value), 32'(m_value));
    chk("key_code", 32'(key_code), 32'(m_key));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("key_pressed", 32'(key_pressed), 32'(m_pressed));
    chk("dv_back_to_back", 32'(prev_valid & digit_valid), 32'd0);
    prev_valid = digit_valid;
    if (digit_valid) n_pulses++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int r, input int c, input int hold_ticks);
    keys = '0;
    keys[4*r+c] = 1'b1;
    cyc(hold_ticks * SCAN_DIV);
    keys = '0;
    cyc(12 * SCAN_DIV);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 400 && m_phase != p; i++) cyc(1);
    chk("wait_phase", 32'(m_phase), 32'(p));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row_n"}, 32'(row_n), 32'h0000_000E);
    chk({tag, "_value"}, 32'(value), 32'h0);
    chk({tag, "_key_code"}, 32'(key_code), 32'h0);
    chk({tag, "_digit_valid"}, 32'(digit_valid), 32'h0);
    chk({tag, "_key_pressed"}, 32'(key_pressed), 32'h0);
  endtask

  initial begin
    int p0;
    cyc(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(1);

    // Single key row1/col2
    p0 = n_pulses;
    press(1, 2, 20);
    chk("t1_value", 32'(value), 32'h0006);
    chk("t1_key_code", 32'(key_code), 32'h6);
    chk("t1_pulses", 32'(n_pulses - p0), 32'd1);
    chk("t1_released", 32'(key_pressed), 32'd0);

    // Four-digit entry, then a fifth digit pushes the oldest out
    press(0, 1, 20); press(0, 2, 20); press(0, 3, 20); press(1, 0, 20);
    chk("t2_value_1234", 32'(value), 32'h1234);
    press(1, 1, 20);
    chk("t2_value_2345", 32'(value), 32'h2345);

    // Bounce on row2/col0: two low samples only
    p0 = n_pulses;
    for (int i = 0; i < 64 && !(m_row == 2 && m_div == 0); i++) cyc(1);
    chk("t3_sync_row2", 32'(m_row * 16 + m_div), 32'h20);
    keys = '0; keys[8] = 1'b1;
    cyc(8);
    keys = '0;
    cyc(5);
    chk("t3_row3_next", 32'(row_n), 32'h7);
    chk("t3_pulses", 32'(n_pulses - p0), 32'd0);
    chk("t3_value", 32'(value), 32'h2345);

    // Two columns in the same row; long hold gives one pulse
    p0 = n_pulses;
    keys = '0; keys[1] = 1'b1; keys[3] = 1'b1;
    cyc(20 * SCAN_DIV);
    keys = '0;
    cyc(12 * SCAN_DIV);
    chk("t4_key_code", 32'(key_code), 32'h1);
    chk("t4_pulses_dual", 32'(n_pulses - p0), 32'd1);
    p0 = n_pulses;
    press(0, 1, 100);
    chk("t4_pulses_hold", 32'(n_pulses - p0), 32'd1);

    // Reset mid-DEBOUNCE, then mid-HELD
    keys = '0; keys[9] = 1'b1;
    wait_phase(1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_deb");
    keys = '0;
    cyc(3);
    rst_n = 1'b1;
    p0 = n_pulses;
    cyc(20 * SCAN_DIV);
    chk("t5_deb_pulses", 32'(n_pulses - p0), 32'd0);
    keys = '0; keys[9] = 1'b1;
    wait_phase(2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_held");
    keys = '0;
    cyc(3);
    rst_n = 1'b1;
    p0 = n_pulses;
    cyc(20 * SCAN_DIV);
    chk("t5_held_pulses", 32'(n_pulses - p0), 32'd0);
    chk("t5_held_value", 32'(value), 32'h0);

    // Key F behaviour
    do_reset();
    press(2, 2, 20); press(2, 3, 20);
    chk("t6_value_ab", 32'(value), 32'h00AB);
    p0 = n_pulses;
    press(3, 3, 20);
    chk("t6_key_code", 32'(key_code), 32'hF);
`ifdef KEYPAD_CLEAR_EN
    chk("t6_value_clear", 32'(value), 32'h0000);
    chk("t6_pulses", 32'(n_pulses - p0), 32'd0);
`else
    chk("t6_value_shift", 32'(value), 32'h0ABF);
    chk("t6_pulses", 32'(n_pulses - p0), 32'd1);
`endif

    // Randomised presses, chatter, extra keys and stray resets
    for (int it = 0; it < 60; it++) begin
      int r, c, hold;
      bit chatter;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      chatter = ($urandom_range(0, 4) == 0);
      keys = '0;
      keys[4*r+c] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(0, 80);
      for (int k = 0; k < hold; k++) begin
        if (chatter) keys[4*r+c] = 1'($urandom_range(0, 1));
        cyc(1);
      end
      keys = '0;
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      cyc($urandom_range(4, 70));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Scans a 4x4 matrix keypad and debounces key presses.
- Shifts each accepted key into a 16-bit, 4-hex-digit entry register, newest digit in the least significant nibble.
- This is the input-side producer for the team's four-digit seven-segment display path: its value output drives the 16-bit word the display path renders.

Parameters:
- SCAN_DIV, 50000, G_CLOCK_50 cycles per row dwell (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_TICKS, 20, consecutive identical scan samples needed to accept a press or a release; minimum 1.

Ports:
- G_CLOCK_50  input  1  system clock, 50 MHz.
- G_RESET_N  input  1  asynchronous, active-low reset.
- col_n  input  4  keypad columns, pulled up; low means a key is closed in the driven row; asynchronous to the clock.
- row_n  output  4  keypad row drive, one-cold.
- value  output  16  entry register, 4 hex digits.
- key_code  output  4  code of the last accepted key.
- digit_valid  output  1  one-cycle pulse per accepted key.
- key_pressed  output  1  high while an accepted key is held.

Behaviour:
- Interface: one clock, G_CLOCK_50; reset G_RESET_N is asynchronous and active-low. All state is cleared immediately on assertion; release takes effect on a clock edge.
- Reset values: row_n=4'b1110, value=16'h0000, key_code=0, digit_valid=0, key_pressed=0, state=SCAN, all counters=0.
- Reset during any state aborts the operation; no digit_valid is produced.
- col_n passes through a 2-flop synchronizer before use.
- A divider counts 0..SCAN_DIV-1. A sample tick occurs on the cycle where the divider equals SCAN_DIV-1. The synchronized columns are sampled only on ticks.
- Key code = 4*row + col (row 0..3, col 0..3). If several columns are low, the lowest col index wins.
- SCAN state:
  - At each tick, if any column is low, latch the candidate code, set the debounce count to 1 and go to DEBOUNCE; the row is not advanced.
  - Otherwise advance the row: 0->1->2->3->0 wraps.
  - row_n = ~(1<<row).
- DEBOUNCE state:
  - row_n is frozen.
  - At each tick, if the candidate code is still the winning low column, increment the count. Otherwise return to SCAN and advance the row.
  - When the count reaches DEBOUNCE_TICKS, accept the key on that same edge:
    - value <= {value[11:0], code}, so the oldest digit falls off.
    - key_code <= code.
    - digit_valid high for exactly the next cycle.
    - key_pressed <= 1.
    - Go to HELD.
  - If DEBOUNCE_TICKS=1, acceptance happens on the edge of the first detecting tick, directly from SCAN.
- HELD state:
  - row_n is frozen.
  - At each tick, if the held column is high, increment the release count; any low sample resets it to 0.
  - When the release count reaches DEBOUNCE_TICKS: key_pressed <= 0, return to SCAN, advance the row.
  - Holding a key yields exactly one digit_valid; there is no auto-repeat.
  - Presses in other rows are ignored while the row is locked.
- digit_valid never asserts in two consecutive cycles.
- Minimum spacing between digit_valid pulses is 2*DEBOUNCE_TICKS ticks.

Optional Feature:
- Macro: KEYPAD_CLEAR_EN.
- Defined: key code 4'hF is a clear key. On acceptance, value <= 16'h0000, key_code <= 4'hF and key_pressed <= 1, with no digit_valid pulse. Release behaviour is unchanged.
- Undefined: 4'hF shifts into value like any other key and pulses digit_valid.

Test Plan:
1. SCAN_DIV=4, DEBOUNCE_TICKS=3. Hold row1/col2 closed, then release -> exactly one digit_valid; value=16'h0006, key_code=6; key_pressed rises with the pulse and falls 3 ticks after release; row scanning resumes.
2. Press keys 1, 2, 3, 4 at (0,1), (0,2), (0,3), (1,0), each held and released -> value=16'h1234. A fifth key, 5 at (1,1) -> value=16'h2345.
3. Bounce: row2/col0 low for 2 ticks, then high -> no digit_valid, value unchanged; scanning continues from row3.
4. Row0/col1 and row0/col3 closed together -> key_code=1. Hold row0/col1 for 100 ticks -> a single digit_valid.
5. Assert G_RESET_N low mid-DEBOUNCE and mid-HELD -> outputs immediately at reset values; no pulse after release.
6. KEYPAD_CLEAR_EN defined: with value=16'h00AB, press row3/col3 -> value=16'h0000, key_code=F, no digit_valid. Undefined: the same press gives value=16'h0ABF with a pulse.
